// File: rtl/imm_operand_encoder_if.sv
// ---------------------------------------------------------------------------
// imm_operand_encoder_if
// Request/result bundle for the immediate-operand encoder.
//   start          : request strobe, honoured only while busy is low
//   value          : 32-bit constant to encode, captured with start
//   busy           : encoder is working on an accepted request
//   done           : one-cycle pulse, result outputs are valid
//   encodable      : 1 when value fits the rotated 8-bit immediate form
//   shift_operand  : {rotate_imm[3:0], imm8[7:0]}, zero when not encodable
// master = requester, slave = encoder.
// ---------------------------------------------------------------------------
interface imm_operand_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        encodable;
    logic [11:0] shift_operand;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  encodable,
        input  shift_operand
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output encodable,
        output shift_operand
    );
endinterface

// File: rtl/imm_operand_encoder.sv
// ---------------------------------------------------------------------------
// imm_operand_encoder
// Iteratively maps a 32-bit constant onto the ARM data-processing immediate
// form {rotate_imm, imm8} with value == ROR(imm8, 2*rotate_imm). One rotation
// is tested per cycle in ascending order, so the smallest valid rotate_imm
// is reported.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : imm_operand_encoder_if.slave (start/value in, busy/done/result out)
// ---------------------------------------------------------------------------
module imm_operand_encoder (
    input  logic                  clk,
    input  logic                  rst,
    imm_operand_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic [31:0] t_q, t_d;          // ROL(val_q, 2*rot_q), registered
    logic [3:0]  rot_q, rot_d;
    logic        primed_q, primed_d; // t_q holds the rotation of rot_q
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        encodable_q, encodable_d;
    logic [11:0] shift_operand_q, shift_operand_d;

    // Rotation fed into t_d: the current rot on the priming cycle, the next
    // one while stepping through the search.
    logic [3:0]  rot_sel;
    logic [4:0]  rot_amt;
    logic [63:0] rot_dbl;
    logic [31:0] rol_val;
    logic        match;
    logic        last_rot;

    assign rot_sel  = primed_q ? (rot_q + 4'd1) : rot_q;
    assign rot_amt  = {rot_sel, 1'b0};
    // Upper half of {v,v} << n is a pure cyclic left rotate by n.
    assign rot_dbl  = {val_q, val_q} << rot_amt;
    assign rol_val  = rot_dbl[63:32];
    assign match    = primed_q && (t_q[31:8] == 24'd0);
    assign last_rot = (rot_q == 4'd15);

    // State register and all datapath/result flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            val_q           <= 32'd0;
            t_q             <= 32'd0;
            rot_q           <= 4'd0;
            primed_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            encodable_q     <= 1'b0;
            shift_operand_q <= 12'h000;
        end else begin
            state_q         <= state_d;
            val_q           <= val_d;
            t_q             <= t_d;
            rot_q           <= rot_d;
            primed_q        <= primed_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            encodable_q     <= encodable_d;
            shift_operand_q <= shift_operand_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start)
                    state_d = S_SEARCH;
            end
            S_SEARCH: begin
                if (primed_q && (match || last_rot))
                    state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath logic
    always_comb begin
        val_d           = val_q;
        t_d             = t_q;
        rot_d           = rot_q;
        primed_d        = primed_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        encodable_d     = encodable_q;
        shift_operand_d = shift_operand_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    val_d           = bus.value;
                    rot_d           = 4'd0;
                    primed_d        = 1'b0;
                    busy_d          = 1'b1;
                    encodable_d     = 1'b0;
                    shift_operand_d = 12'h000;
                end
            end
            S_SEARCH: begin
                if (!primed_q) begin
                    // First search cycle only loads the rotation-0 candidate.
                    t_d      = rol_val;
                    primed_d = 1'b1;
                end else if (match) begin
                    shift_operand_d = {rot_q, t_q[7:0]};
                    encodable_d     = 1'b1;
                    done_d          = 1'b1;
                end else if (last_rot) begin
                    shift_operand_d = 12'h000;
                    encodable_d     = 1'b0;
                    done_d          = 1'b1;
                end else begin
                    rot_d = rot_q + 4'd1;
                    t_d   = rol_val;
                end
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.encodable     = encodable_q;
    assign bus.shift_operand = shift_operand_q;

endmodule

// File: tb/tb_imm_operand_encoder.sv
module tb_imm_operand_encoder;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    imm_operand_encoder_if bus_if ();

    imm_operand_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until the encoder is idle.
    task automatic wait_idle();
        int n;
        n = 0;
        while (bus_if.busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Issue one request and measure edges from acceptance to done (99 = timeout).
    task automatic issue(input logic [31:0] v, input bit change_val, output int lat);
        bit seen;
        wait_idle();
        @(negedge clk);
        bus_if.value = v;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        if (change_val) bus_if.value = 32'h0000_0101;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_if.done) seen = 1'b1;
        end
        if (!seen) lat = 99;
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus_if.busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy got %b want 0", bus_if.busy);
        end
        tests_run++;
        if (bus_if.done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_done got %b want 0", bus_if.done);
        end
        tests_run++;
        if (bus_if.encodable !== 1'b0) begin
            tests_failed++; $display("FAIL reset_encodable got %b want 0", bus_if.encodable);
        end
        tests_run++;
        if (bus_if.shift_operand !== 12'h000) begin
            tests_failed++; $display("FAIL reset_shift got %h want 000", bus_if.shift_operand);
        end
        $display("[TB] reset: busy=%b done=%b enc=%b op=%h", bus_if.busy, bus_if.done,
                 bus_if.encodable, bus_if.shift_operand);
    endtask

    task automatic test_encode();
        logic [31:0] vals [6];
        logic [11:0] exp_op [6];
        logic        exp_en [6];
        int          exp_lat [6];
        int          lat;
        vals = '{32'h0000_0000, 32'h0000_0004, 32'hFF00_0000,
                 32'hF000_000F, 32'h0000_03FC, 32'h0000_0101};
        exp_op  = '{12'h000, 12'h004, 12'h4FF, 12'h2FF, 12'hFFF, 12'h000};
        exp_en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_lat = '{2, 2, 6, 4, 17, 17};
        for (int k = 0; k < 6; k++) begin
            // Vector 2 also changes value after acceptance; it must not matter.
            issue(vals[k], (k == 2), lat);
            $display("[TB] encode value=%h lat=%0d enc=%b op=%h", vals[k], lat,
                     bus_if.encodable, bus_if.shift_operand);
            tests_run++;
            if (lat != exp_lat[k]) begin
                tests_failed++;
                $display("FAIL latency value=%h got %0d want %0d", vals[k], lat, exp_lat[k]);
            end
            tests_run++;
            if (bus_if.encodable !== exp_en[k]) begin
                tests_failed++;
                $display("FAIL encodable value=%h got %b want %b", vals[k], bus_if.encodable, exp_en[k]);
            end
            tests_run++;
            if (bus_if.shift_operand !== exp_op[k]) begin
                tests_failed++;
                $display("FAIL shift_operand value=%h got %h want %h", vals[k], bus_if.shift_operand, exp_op[k]);
            end
        end
    endtask

    task automatic test_result_hold();
        int lat;
        issue(32'h0000_03FC, 1'b0, lat);
        repeat (5) @(posedge clk);
        #1;
        $display("[TB] hold: busy=%b done=%b enc=%b op=%h", bus_if.busy, bus_if.done,
                 bus_if.encodable, bus_if.shift_operand);
        tests_run++;
        if (bus_if.shift_operand !== 12'hFFF || bus_if.encodable !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_result got enc=%b op=%h want enc=1 op=fff", bus_if.encodable, bus_if.shift_operand);
        end
        tests_run++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_idle got busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
        end
    endtask

    task automatic test_start_held();
        int done_cnt;
        int first_done;
        int second_done;
        logic busy_at_18;
        wait_idle();
        @(negedge clk);
        bus_if.value = 32'h0000_0101;
        bus_if.start = 1'b1;
        @(posedge clk);          // E0
        done_cnt = 0; first_done = -1; second_done = -1; busy_at_18 = 1'bx;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 18) busy_at_18 = bus_if.busy;
            if (bus_if.done) begin
                done_cnt++;
                if (first_done < 0) first_done = e;
                else if (second_done < 0) second_done = e;
            end
        end
        bus_if.start = 1'b0;
        $display("[TB] start_held: dones=%0d at %0d,%0d busy@18=%b", done_cnt, first_done,
                 second_done, busy_at_18);
        tests_run++;
        if (done_cnt != 2) begin
            tests_failed++; $display("FAIL held_done_count got %0d want 2", done_cnt);
        end
        tests_run++;
        if (first_done != 17 || second_done != 36) begin
            tests_failed++;
            $display("FAIL held_done_edges got %0d,%0d want 17,36", first_done, second_done);
        end
        tests_run++;
        if (busy_at_18 !== 1'b0) begin
            tests_failed++; $display("FAIL held_busy_gap got %b want 0", busy_at_18);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_search();
        int lat;
        int stray;
        wait_idle();
        @(negedge clk);
        bus_if.value = 32'h0000_03FC;
        bus_if.start = 1'b1;
        @(posedge clk);          // E0
        #1;
        bus_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        $display("[TB] mid_reset: busy=%b done=%b enc=%b op=%h", bus_if.busy, bus_if.done,
                 bus_if.encodable, bus_if.shift_operand);
        tests_run++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_ctrl got busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
        end
        tests_run++;
        if (bus_if.encodable !== 1'b0 || bus_if.shift_operand !== 12'h000) begin
            tests_failed++;
            $display("FAIL midrst_result got enc=%b op=%h want 0 000", bus_if.encodable, bus_if.shift_operand);
        end
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done || bus_if.busy) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++; $display("FAIL midrst_no_inflight got %0d active cycles want 0", stray);
        end
        issue(32'h0000_00AB, 1'b0, lat);
        $display("[TB] after_reset value=000000ab lat=%0d enc=%b op=%h", lat,
                 bus_if.encodable, bus_if.shift_operand);
        tests_run++;
        if (lat != 2) begin
            tests_failed++; $display("FAIL post_rst_latency got %0d want 2", lat);
        end
        tests_run++;
        if (bus_if.encodable !== 1'b1 || bus_if.shift_operand !== 12'h0AB) begin
            tests_failed++;
            $display("FAIL post_rst_result got enc=%b op=%h want 1 0ab", bus_if.encodable, bus_if.shift_operand);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.value = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_encode();
        test_result_hold();
        test_start_held();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
